// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller for a 128-word instruction memory.
// Owns the program counter, presents it combinationally as the memory
// address, and captures the returned word into the IF/ID register.
// Handles stall, redirect (branch/jump), halt and fault, and counts
// issued instructions (saturating) for bring-up and debug.
//
// Flow-control semantics, in one place:
//   - An instruction is "issued" on a rising edge in RUN when neither
//     redirect_i, stall_i nor halt_req_i is asserted. At that edge the
//     word on imem_instr_i is captured, ifid_valid_o goes high and
//     fetch_count_o increments.
//   - stall_i is a hold: while it is high in RUN (and no redirect),
//     PC, IF/ID and the counter keep their values, so a valid word in
//     IF/ID stays presented to decode until the stall drops.
//   - redirect_i has top priority; a legal target costs exactly one
//     bubble (ifid_valid_o low for one cycle), an illegal one faults.

module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 128
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        halt_req_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc_plus4_o,
  output logic        ifid_valid_o,
  output logic [31:0] pc_o,
  output logic [1:0]  state_o,
  output logic [31:0] fetch_count_o
);

  // One past the last legal byte address, and the last legal word address.
  localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_WORDS);
  localparam logic [31:0] LAST_PC  = PC_LIMIT - 32'd4;

  // The numeric values are visible on state_o, so they are fixed.
  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2,
    ST_FAULT  = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] ifid_instr_q;
  logic [31:0] ifid_pc_plus4_q;
  logic        ifid_valid_q;
  logic [31:0] fetch_count_q;

  logic [31:0] pc_plus4_d;
  logic [31:0] fetch_count_d;
  logic        redirect_legal;
  logic        at_last_word;

  // Next-value helpers shared by the state machine below.
  always_comb begin
    pc_plus4_d     = pc_q + 32'd4;
    fetch_count_d  = (&fetch_count_q) ? fetch_count_q : fetch_count_q + 32'd1;
    redirect_legal = (redirect_pc_i[1:0] == 2'b00) && (redirect_pc_i < PC_LIMIT);
    at_last_word   = (pc_q == LAST_PC);
  end

  // Fetch state machine with the PC, IF/ID register and issue counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= ST_BOOT;
      pc_q            <= RESET_PC;
      ifid_instr_q    <= '0;
      ifid_pc_plus4_q <= '0;
      ifid_valid_q    <= 1'b0;
      fetch_count_q   <= '0;
    end else begin
      case (state_q)
        // Single settling cycle after reset release; nothing is issued.
        ST_BOOT: begin
          state_q <= ST_RUN;
        end

        ST_RUN: begin
          if (redirect_i) begin
            // Redirect wins over stall and halt; the word fetched from the
            // old path this cycle is squashed.
            if (redirect_legal) begin
              pc_q         <= redirect_pc_i;
              ifid_instr_q <= '0;
              ifid_valid_q <= 1'b0;
            end else begin
              state_q      <= ST_FAULT;
              ifid_valid_q <= 1'b0;
            end
          end else if (stall_i) begin
            // Everything holds.
          end else if (halt_req_i) begin
            ifid_valid_q <= 1'b0;
            state_q      <= ST_HALTED;
          end else begin
            ifid_instr_q    <= imem_instr_i;
            ifid_pc_plus4_q <= pc_plus4_d;
            ifid_valid_q    <= 1'b1;
            fetch_count_q   <= fetch_count_d;
            // The last word is issued but the PC does not wrap to zero.
            if (at_last_word) begin
              state_q <= ST_HALTED;
            end else begin
              pc_q <= pc_plus4_d;
            end
          end
        end

        // Only a redirect leaves HALTED; stall and halt are ignored here.
        ST_HALTED: begin
          ifid_valid_q <= 1'b0;
          if (redirect_i) begin
            if (redirect_legal) begin
              pc_q         <= redirect_pc_i;
              ifid_instr_q <= '0;
              state_q      <= ST_RUN;
            end else begin
              state_q <= ST_FAULT;
            end
          end
        end

        // Sticky until reset; PC stays at the pre-fault value.
        ST_FAULT: begin
          ifid_valid_q <= 1'b0;
        end

        default: begin
          state_q      <= ST_FAULT;
          ifid_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr_o     = pc_q;
  assign pc_o            = pc_q;
  assign ifid_instr_o    = ifid_instr_q;
  assign ifid_pc_plus4_o = ifid_pc_plus4_q;
  assign ifid_valid_o    = ifid_valid_q;
  assign state_o         = state_q;
  assign fetch_count_o   = fetch_count_q;

endmodule
